// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control logic: hazard FSM
// states, forwarding-select encodings and IDEX control-byte bit positions.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_LAUNCH = 2'd1,
    MD_BUSY   = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_ALUOP_LO = 3;
  localparam int CTRL_ALUOP_HI = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_REGDST   = 7;

  // Newest producer wins: EXMEM over MEMWB; $0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic       exmem_rw,
    input logic [4:0] exmem_w,
    input logic       memwb_rw,
    input logic [4:0] memwb_w,
    input logic [4:0] src
  );
    if (exmem_rw && (exmem_w != 5'd0) && (exmem_w == src)) begin
      return FWD_EXMEM;
    end else if (memwb_rw && (memwb_w != 5'd0) && (memwb_w == src)) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding: selects regfile, EXMEM or MEMWB data for the
// rs (operand A) and rt (operand B) sources of the instruction in EX.
module forwarding_unit
  import mips_pkg::*;
(
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_wreg,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_wreg,
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  logic [4:0] src [2];
  logic [1:0] sel [2];

  assign src[0] = idex_rs;
  assign src[1] = idex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign sel[gi] = fwd_pick(exmem_regwrite, exmem_wreg, memwb_regwrite, memwb_wreg, src[gi]);
  end

  assign forward_a = sel[0];
  assign forward_b = sel[1];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use
// stalls, branch squash, mult/div launch/wait with timeout, and forwarding.
module pipeline_hazard_controller
  import mips_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_req,
  input  logic [7:0]       idex_ctrl,
  input  logic [4:0]       idex_wreg,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_wreg,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_wreg,
  input  logic             ex_branch_taken,
  input  logic             md_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             md_go,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int             TO_W    = $clog2(MD_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  hz_state_t        state_reg, state_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             md_error_reg, md_error_next;
  logic             md_pass_reg, md_pass_next;
  logic [CNT_W-1:0] stall_reg;

  logic       lu;
  logic       pc_en, ifid_en, flush_en, bubble_en, go_en;
  logic [1:0] fwd_a, fwd_b;
  logic       unused_ctrl;

  assign unused_ctrl = ^{idex_ctrl[CTRL_REGDST], idex_ctrl[CTRL_MEMWRITE],
                         idex_ctrl[CTRL_MEMTOREG], idex_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO],
                         idex_ctrl[CTRL_ALUSRC], idex_ctrl[CTRL_REGWRITE]};

  assign lu = idex_ctrl[CTRL_MEMREAD] && (idex_wreg != 5'd0) &&
              ((idex_wreg == id_rs) || (id_uses_rt && (idex_wreg == id_rt)));

  // md_pass marks the first RUN cycle after a mult/div finishes, so the
  // still-resident ID instruction is issued instead of being relaunched.
  always_comb begin
    state_next    = state_reg;
    to_cnt_next   = to_cnt_reg;
    md_error_next = md_error_reg;
    md_pass_next  = 1'b0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    flush_en      = 1'b0;
    bubble_en     = 1'b0;
    go_en         = 1'b0;
    case (state_reg)
      RUN: begin
        if (ex_branch_taken) begin
          flush_en  = 1'b1;
          bubble_en = 1'b1;
        end else if (lu) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          bubble_en    = 1'b1;
          md_pass_next = md_pass_reg;
        end else if (id_md_req && !md_pass_reg) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          bubble_en  = 1'b1;
          state_next = MD_LAUNCH;
        end
      end
      MD_LAUNCH: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        bubble_en   = 1'b1;
        go_en       = 1'b1;
        to_cnt_next = '0;
        state_next  = MD_BUSY;
      end
      MD_BUSY: begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        bubble_en = 1'b1;
        if (md_done) begin
          state_next   = RUN;
          md_pass_next = 1'b1;
        end else if (to_cnt_reg == TO_LAST) begin
          md_error_next = 1'b1;
          state_next    = RUN;
          md_pass_next  = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= RUN;
      to_cnt_reg   <= '0;
      md_error_reg <= 1'b0;
      md_pass_reg  <= 1'b0;
      stall_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      to_cnt_reg   <= to_cnt_next;
      md_error_reg <= md_error_next;
      md_pass_reg  <= md_pass_next;
      if (!pc_write && (stall_reg != '1)) begin
        stall_reg <= stall_reg + CNT_W'(1);
      end
    end
  end

  forwarding_unit u_fwd (
    .exmem_regwrite (exmem_regwrite),
    .exmem_wreg     (exmem_wreg),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wreg     (memwb_wreg),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .forward_a      (fwd_a),
    .forward_b      (fwd_b)
  );

  // While reset is held the pipeline is frozen and EX is bubbled.
  assign pc_write     = reset_n & pc_en;
  assign ifid_write   = reset_n & ifid_en;
  assign ifid_flush   = reset_n & flush_en;
  assign idex_bubble  = ~reset_n | bubble_en;
  assign forward_a    = reset_n ? fwd_a : FWD_REG;
  assign forward_b    = reset_n ? fwd_b : FWD_REG;
  assign md_go        = reset_n & go_en;
  assign md_error     = md_error_reg;
  assign stall_cycles = stall_reg;

  // Stalls bubble EX, so a taken branch can only resolve while running.
  a_branch_only_in_run: assert property (
    @(posedge clk) disable iff (!reset_n) (state_reg != RUN) |-> !ex_branch_taken
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: each cycle's expected
// outputs are queued with the stimulus and checked just before the next edge.
module tb_pipeline_hazard_controller;
  import mips_pkg::*;

  localparam int          CNT_W      = 6;
  localparam int          MD_TIMEOUT = 8;
  localparam logic [5:0]  SAT        = 6'h3F;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       id_rs, id_rt;
  logic             id_uses_rt, id_md_req;
  logic [7:0]       idex_ctrl;
  logic [4:0]       idex_wreg, idex_rs, idex_rt;
  logic             exmem_regwrite, memwb_regwrite;
  logic [4:0]       exmem_wreg, memwb_wreg;
  logic             ex_branch_taken, md_done;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, md_go, md_error;
  logic [1:0]       forward_a, forward_b;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md_req(id_md_req),
    .idex_ctrl(idex_ctrl), .idex_wreg(idex_wreg), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg),
    .memwb_regwrite(memwb_regwrite), .memwb_wreg(memwb_wreg),
    .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .forward_a(forward_a), .forward_b(forward_b),
    .md_go(md_go), .md_error(md_error), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic pw, iw, fl, bub;
    logic [1:0] fa, fb;
    logic go, err;
    logic [CNT_W-1:0] st;
  } outs_t;

  typedef struct packed {
    logic req, done, br;
    logic pw, iw, fl, bub, go;
  } step_t;

  outs_t            exp_q[$];
  outs_t            obs;
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic             exp_err = 1'b0;
  logic [1:0]       exp_fa = FWD_REG;
  logic [1:0]       exp_fb = FWD_REG;

  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, forward_a, forward_b,
                md_go, md_error, stall_cycles};

  function automatic step_t st(input logic req, done, br, pw, iw, fl, bub, go);
    return {req, done, br, pw, iw, fl, bub, go};
  endfunction

  localparam step_t RUN_OK = 8'b000_11000;

  task automatic set_quiet();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1; id_md_req = 1'b0;
    idex_ctrl = 8'h00; idex_wreg = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
    exmem_regwrite = 1'b0; exmem_wreg = 5'd0; memwb_regwrite = 1'b0; memwb_wreg = 5'd0;
    ex_branch_taken = 1'b0; md_done = 1'b0;
    exp_fa = FWD_REG; exp_fb = FWD_REG;
  endtask

  // Apply one cycle of handshake stimulus, queue its expectation, wait to the sample point.
  task automatic drive(input step_t s);
    id_md_req = s.req; md_done = s.done; ex_branch_taken = s.br;
    exp_q.push_back({s.pw, s.iw, s.fl, s.bub, exp_fa, exp_fb, s.go, exp_err, exp_stall});
    @(negedge clk);
  endtask

  task automatic next_cycle(input logic pw);
    @(posedge clk); #1;
    if (!pw && exp_stall != SAT) exp_stall = exp_stall + CNT_W'(1);
  endtask

  task automatic test_reset();
    outs_t e;
    reset_n = 1'b0;
    set_quiet();
    exmem_regwrite = 1'b1; exmem_wreg = 5'd9; idex_rs = 5'd9; idex_rt = 5'd9;
    idex_ctrl = 8'b00100101; idex_wreg = 5'd17; id_rs = 5'd17;
    exp_q.push_back({4'b0001, FWD_REG, FWD_REG, 2'b00, CNT_W'(0)});
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_forced got=%h exp=%h", obs, e); end
    set_quiet();
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(RUN_OK);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    next_cycle(e.pw);
  endtask

  task automatic test_load_use();
    outs_t e;
    logic [7:0] c [6];
    logic [4:0] w [6], rs [6], rt [6];
    logic       u [6], stl [6];
    c   = '{8'b00100101, 8'h00, 8'h04, 8'h04, 8'h04, 8'h01};
    w   = '{5'd17, 5'd17, 5'd17, 5'd17, 5'd0, 5'd17};
    rs  = '{5'd17, 5'd17, 5'd3, 5'd3, 5'd0, 5'd17};
    rt  = '{5'd2, 5'd2, 5'd17, 5'd17, 5'd0, 5'd2};
    u   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    stl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    set_quiet();
    for (int i = 0; i < 6; i++) begin
      idex_ctrl = c[i]; idex_wreg = w[i]; id_rs = rs[i]; id_rt = rt[i]; id_uses_rt = u[i];
      drive(st(0, 0, 0, !stl[i], !stl[i], 0, stl[i], 0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL load_use[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_forwarding();
    outs_t e;
    logic       erw [6], mrw [6];
    logic [4:0] ew [6], mw [6], rs [6], rt [6];
    logic [1:0] fa [6], fb [6];
    erw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ew  = '{5'd9, 5'd0, 5'd9, 5'd9, 5'd0, 5'd5};
    mrw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    mw  = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 5'd6};
    rs  = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 5'd5};
    rt  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd6};
    fa  = '{FWD_EXMEM, FWD_MEMWB, FWD_EXMEM, FWD_MEMWB, FWD_REG, FWD_EXMEM};
    fb  = '{FWD_REG, FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_REG, FWD_MEMWB};
    set_quiet();
    for (int i = 0; i < 6; i++) begin
      exmem_regwrite = erw[i]; exmem_wreg = ew[i]; memwb_regwrite = mrw[i]; memwb_wreg = mw[i];
      idex_rs = rs[i]; idex_rt = rt[i]; exp_fa = fa[i]; exp_fb = fb[i];
      drive(RUN_OK);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL forward[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
    set_quiet();
  endtask

  task automatic test_branch();
    outs_t e;
    step_t s [4];
    logic  lu_on [4];
    s     = '{st(1, 0, 1, 1, 1, 1, 1, 0), RUN_OK, st(0, 0, 1, 1, 1, 1, 1, 0), RUN_OK};
    lu_on = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_quiet();
      if (lu_on[i]) begin idex_ctrl = 8'b00100101; idex_wreg = 5'd17; id_rs = 5'd17; end
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL branch[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_multdiv();
    outs_t e;
    step_t s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 1, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < 4; k++) s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 1, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(st(0, 1, 0, 1, 1, 0, 0, 0));
    set_quiet();
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL multdiv[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_back_to_back();
    outs_t e;
    step_t s[$];
    for (int k = 0; k < 2; k++) begin
      s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
      s.push_back(st(1, 0, 0, 0, 0, 0, 1, 1));
      s.push_back(st(1, 1, 0, 0, 0, 0, 1, 0));
      s.push_back(st(1, 0, 0, 1, 1, 0, 0, 0));
    end
    s.push_back(RUN_OK);
    set_quiet();
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_done_at_timeout();
    outs_t e;
    step_t s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < MD_TIMEOUT - 1; k++) s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 1, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(RUN_OK);
    set_quiet();
    foreach (s[i]) begin
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL done_at_timeout[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_timeout();
    outs_t e;
    step_t s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < MD_TIMEOUT; k++) s.push_back(st(1, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 4; k++) s.push_back(RUN_OK);
    set_quiet();
    foreach (s[i]) begin
      if (i == MD_TIMEOUT + 2) exp_err = 1'b1;
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL timeout[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_saturation();
    outs_t e;
    set_quiet();
    idex_ctrl = 8'b00000100; idex_wreg = 5'd20; id_rs = 5'd20;
    for (int i = 0; i < 71; i++) begin
      if (i == 70) set_quiet();
      drive(i == 70 ? RUN_OK : st(0, 0, 0, 0, 0, 0, 1, 0));
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL saturate[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  task automatic test_async_reset();
    outs_t e;
    step_t s [4];
    s = '{st(1, 0, 0, 0, 0, 0, 1, 0), st(1, 0, 0, 0, 0, 0, 1, 1),
          st(1, 0, 0, 0, 0, 0, 1, 0), st(1, 0, 0, 0, 0, 0, 1, 0)};
    set_quiet();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL async_pre[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
    exmem_regwrite = 1'b1; exmem_wreg = 5'd9; idex_rs = 5'd9; idex_rt = 5'd9;
    #2 reset_n = 1'b0;
    exp_q.push_back({4'b0001, FWD_REG, FWD_REG, 2'b00, CNT_W'(0)});
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL async_midcycle got=%h exp=%h", obs, e); end
    @(negedge clk); #1;
    set_quiet();
    reset_n = 1'b1;
    exp_stall = '0; exp_err = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(RUN_OK);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL async_post[%0d] got=%h exp=%h", i, obs, e); end
      next_cycle(e.pw);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_multdiv();
    test_back_to_back();
    test_done_at_timeout();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Inputs: register-use fields from ID, IDEX control byte and destinations from IDEX/EXMEM/MEMWB, branch resolution from EX, and a multi-cycle mult/div unit handshake.
- Outputs: PC and IF/ID write enables, IF/ID flush, ID/EX bubble, EX operand forwarding selects, and the mult/div launch pulse.
- Also keeps a saturating stall counter and a sticky mult/div timeout flag.

Parameters:
CNT_W, 16, width of stall_cycles counter
MD_TIMEOUT, 64, maximum cycles in MD_BUSY before abort (>=2)

Ports:
clk  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt (R-format, beq, sw)
id_md_req  in  1  ID instruction is mult/div
idex_ctrl  in  8  IDEX control byte: [0]RegWrite [2]MemRead
idex_wreg  in  5  IDEX write-register (post-RegDst)
idex_rs  in  5  rs of instruction in EX
idex_rt  in  5  rt of instruction in EX
exmem_regwrite  in  1  EXMEM RegWrite
exmem_wreg  in  5  EXMEM write-register
memwb_regwrite  in  1  MEMWB RegWrite
memwb_wreg  in  5  MEMWB write-register
ex_branch_taken  in  1  branch in EX resolved taken
md_done  in  1  mult/div result ready (1-cycle pulse)
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  zero IF/ID on next edge
idex_bubble  out  1  zero IDEX control byte on next edge
forward_a  out  2  EX operand A select: 00 regfile, 10 EXMEM, 01 MEMWB
forward_b  out  2  EX operand B select, same encoding
md_go  out  1  1-cycle mult/div launch pulse
md_error  out  1  sticky: mult/div timed out
stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset_n low, async):
  - state=RUN, md_go=0, md_error=0, stall_cycles=0, timeout counter=0.
  - Combinational outputs are forced: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, forward_a=forward_b=00.
- FSM states: RUN, MD_LAUNCH, MD_BUSY.
- Load-use hazard `lu` = idex_ctrl[2] & (idex_wreg!=0) & (idex_wreg==id_rs | (id_uses_rt & idex_wreg==id_rt)).
- Priority in RUN (highest first):
  1. ex_branch_taken:
     - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - lu and id_md_req are ignored because the ID instruction is squashed.
     - Stay in RUN.
  2. lu:
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, for exactly one cycle.
     - Stay in RUN; the hazard clears once the load advances.
  3. id_md_req:
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
     - Go to MD_LAUNCH.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- MD_LAUNCH:
  - md_go=1 for this cycle only; stall outputs as in RUN/md_req.
  - Clear timeout counter; go to MD_BUSY.
- MD_BUSY:
  - Stall outputs held and timeout counter increments.
  - md_done: next cycle is RUN; the ID instruction proceeds with pc_write=ifid_write=1 and idex_bubble=0 in RUN, so it is issued exactly once.
  - Counter reaches MD_TIMEOUT-1 without md_done: set md_error=1 and return to RUN.
  - md_done on the same cycle as timeout: done wins and md_error is not set.
- ex_branch_taken is ignored outside RUN. It cannot occur then, because stalls bubble EX; this is an assertion target.
- md_done outside MD_BUSY is ignored.
- stall_cycles increments on every clock edge where pc_write=0 and reset_n=1, and saturates at all-ones.
- Forwarding is purely combinational, evaluated every cycle regardless of state.
  - forward_a=10 if exmem_regwrite & exmem_wreg!=0 & exmem_wreg==idex_rs.
  - Otherwise forward_a=01 if memwb_regwrite & memwb_wreg!=0 & memwb_wreg==idex_rs.
  - Otherwise 00.
  - forward_b is the same logic against idex_rt.
  - EXMEM beats MEMWB; register $0 is never forwarded.
- Reset mid-MD_BUSY: immediate return to RUN, no md_go, md_error cleared.

Decomposition:
- Shared package mips_pkg holds:
  - FSM state enum.
  - Forward-select constants FWD_REG=00, FWD_EXMEM=10, FWD_MEMWB=01.
  - IDEX control-bit indices (CTRL_REGWRITE=0, CTRL_ALUSRC=1, CTRL_MEMREAD=2, CTRL_ALUOP=4:3, CTRL_MEMTOREG=5, CTRL_MEMWRITE=6, CTRL_REGDST=7).
- Sub-module forwarding_unit contains the combinational forward_a/forward_b logic, instanced once.

Test Plan:
1. Load-use: idex_ctrl=8'b00100101, idex_wreg=17, id_rs=17 -> one cycle of pc_write=0, idex_bubble=1, stall_cycles=1; next cycle with idex_ctrl cleared -> pc_write=1.
2. Forwarding: exmem_regwrite=1, exmem_wreg=9, memwb_regwrite=1, memwb_wreg=9, idex_rs=9, idex_rt=0 -> forward_a=10, forward_b=00. Then set exmem_wreg=0 -> forward_a=01.
3. Branch over load-use: ex_branch_taken=1 with lu conditions true -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall counted.
4. Mult/div: id_md_req=1, md_done asserted 5 cycles after md_go -> md_go is a single pulse the cycle after request; pc_write=0 for 7 cycles total; RUN resumes with idex_bubble=0.
5. Timeout: MD_TIMEOUT=8 and md_done never asserted -> md_error=1 after 8 MD_BUSY cycles, state back to RUN, md_error stays 1 until reset.
6. Async reset in MD_BUSY cycle 3 -> outputs take reset values immediately (mid-cycle); after release, state=RUN and stall_cycles=0.
